// File: rtl/mem_port_arbiter.sv
// Arbitrates the single mem data port between instruction fetch (IF) and load/store (LS).
// LS wins by default; a starvation counter forces an IF grant after MAX_WAIT denied cycles.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-2:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  output logic          m_wen,
  output logic [AW-2:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    dbg_wait_cnt,
  output logic          dbg_pend_if,
  output logic          dbg_pend_ls
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  // Handshake: a request is held stable until its gnt; gnt and req high in the
  // same cycle means the access is issued to mem in that cycle.
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       pend_if_q, pend_if_d;
  logic       pend_ls_q, pend_ls_d;
  logic       force_if;
  logic       unused_addr_lsb;

  assign force_if        = (wait_cnt_q >= MAX_W);
  assign unused_addr_lsb = ^{if_addr[0], ls_addr[0]};

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req && (!ls_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  assign m_raddr = if_gnt ? if_addr[AW-1:1] : ls_addr[AW-1:1];
  assign m_wen   = ls_gnt & ls_we;
  assign m_waddr = ls_addr[AW-1:1];
  assign m_wdata = ls_wdata;

  always_comb begin
    pend_if_d  = if_gnt;
    pend_ls_d  = ls_gnt & ~ls_we;
    wait_cnt_d = 4'd0;
    if (if_req && !if_gnt) begin
      wait_cnt_d = (wait_cnt_q == 4'd15) ? 4'd15 : wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      pend_if_q  <= 1'b0;
      pend_ls_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      pend_if_q  <= pend_if_d;
      pend_ls_q  <= pend_ls_d;
    end
  end

  // A response still in flight when rst rises is dropped, not reported.
  assign if_rvalid = pend_if_q & ~rst;
  assign ls_rvalid = pend_ls_q & ~rst;
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign ls_rdata  = ls_rvalid ? m_rdata : '0;

  assign dbg_wait_cnt = wait_cnt_q;
  assign dbg_pend_if  = pend_if_q;
  assign dbg_pend_ls  = pend_ls_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of `mem` (read port 1 plus write port) between two requesters: the instruction-fetch unit (IF) and the load/store unit (LS).
- Grants at most one access per cycle and drives `mem` addresses and write enable.
- Returns read data one cycle after grant, with a per-requester valid.
- Default priority goes to LS; a starvation counter guarantees IF progress.

Parameters:
- MAX_WAIT, 4: consecutive cycles IF may be denied while requesting before it gets forced priority (1..15).
- AW, 16: byte-address width from requesters.
- DW, 16: data width.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF read request; held with if_addr stable until if_gnt
- if_addr  in  AW  IF byte address
- if_gnt  out  1  IF access accepted this cycle (combinational)
- if_rvalid  out  1  IF read data valid (registered)
- if_rdata  out  DW  IF read data
- ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  LS byte address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  LS access accepted this cycle (combinational)
- ls_rvalid  out  1  LS load data valid (registered)
- ls_rdata  out  DW  LS load data
- m_raddr  out  AW-1  word address to mem read port 1
- m_rdata  in  DW  mem read data, valid one cycle after m_raddr
- m_wen  out  1  mem write enable
- m_waddr  out  AW-1  word address to mem write port
- m_wdata  out  DW  mem write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst.
- State:
  - wait_cnt, 4 bits: IF starvation counter.
  - pend_if, pend_ls: read response tags.
- Reset: wait_cnt=0, pend_if=0, pend_ls=0, so if_rvalid=ls_rvalid=0 the cycle after rst is sampled. Reset mid-operation drops any pending response; no rvalid is issued for it.
- Outputs while rst is high: if_gnt=ls_gnt=0 and m_wen=0.
- Priority mode: force_if = (wait_cnt >= MAX_WAIT).
- Grant logic (combinational, at most one grant per cycle):
  - Only if_req: if_gnt=1.
  - Only ls_req: ls_gnt=1.
  - Both, force_if=0: ls_gnt=1, if_gnt=0.
  - Both, force_if=1: if_gnt=1, ls_gnt=0.
  - Neither: no grant, m_wen=0, mem addresses don't-care.
- Memory drive in the grant cycle:
  - m_raddr = granted addr[AW-1:1]; byte-address bit 0 is ignored (no misalignment fault).
  - LS store grant: m_wen=1, m_waddr=ls_addr[AW-1:1], m_wdata=ls_wdata; the write commits at the next posedge.
  - Otherwise m_wen=0.
- Response pipeline:
  - At the posedge after a grant, set pend_if=if_gnt and pend_ls=(ls_gnt & ~ls_we).
  - if_rvalid=pend_if and ls_rvalid=pend_ls.
  - Read-to-data latency is exactly 1 cycle. Back-to-back grants yield back-to-back rvalids.
  - A store never raises ls_rvalid.
- Read data: if_rdata = pend_if ? m_rdata : 0, and ls_rdata = pend_ls ? m_rdata : 0.
- Starvation counter at each posedge:
  - if_req & ~if_gnt: wait_cnt = min(wait_cnt+1, 15).
  - Otherwise (IF granted or not requesting): wait_cnt=0.
- Read-after-write: an LS store followed next cycle by a read of the same word returns the new data. The `mem` write-then-read ordering guarantees this; the arbiter adds no bypass.
- Requester rule: withdrawing req before gnt is legal. It abandons the request and clears wait_cnt if IF.

Test Plan:
- Reset check: hold rst 2 cycles with both reqs high -> no gnt, m_wen=0. After release, first cycle has ls_gnt=1, and if_rvalid=ls_rvalid=0 throughout reset.
- IF-only reads: if_req=1 with if_addr=0x0000, 0x0002, 0x0004 on consecutive cycles (mem words 0x1111, 0x2222, 0x3333) -> if_gnt=1 each cycle, m_raddr=0,1,2, and if_rvalid on cycles 2..4 with if_rdata=0x1111, 0x2222, 0x3333.
- LS store then load: store 0xBEEF to 0x0010, then load 0x0010 -> m_wen=1 with m_waddr=0x0008 in cycle 1, no ls_rvalid after the store, and ls_rvalid=1 with ls_rdata=0xBEEF one cycle after the load grant.
- Starvation (MAX_WAIT=4): ls_req and if_req held high continuously -> LS granted cycles 1..4, IF granted cycle 5, wait_cnt returns to 0, then LS granted cycles 6..9 and IF again at cycle 10.
- Reset mid-operation: grant an LS load and assert rst in the next cycle -> ls_rvalid stays 0, and pend/wait_cnt are 0 after reset.
- Odd address: if_addr=0x0007 -> m_raddr=0x0003, with data identical to if_addr=0x0006.
